keypad_emulator: RTL and testbench

Keypad-side responder for the 3-column × 4-row matrix keypad scan interface. The scanner drives one-hot column selects and reads back one-hot row lines. This block watches `scan_key`, accepts key-press requests over a valid/ready handshake, and drives `touch_key` as a physical key would. It holds the press for a programmed number of full scan rounds, then releases it for a programmed gap. It replaces the physical keypad in bring-up builds and in scanner/display regression benches.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/scan_round_detect.sv | 22 ++
 rtl/keypad_emulator.sv | 96 +++++++++
 tb/tb_keypad_emulator.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad mapping: key codes, one-hot columns/rows and FSM states.
// The scanner imports this too, so both sides decode keys identically.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [2:0] COL0 = 3'b100;
  localparam logic [2:0] COL1 = 3'b010;
  localparam logic [2:0] COL2 = 3'b001;

  typedef enum logic [1:0] {IDLE, ARM, PRESS, GAP} kp_state_t;

  // Column select a key answers to; 0 for illegal codes.
  function automatic logic [2:0] key_col(input logic [3:0] code);
    case (code)
      4'd1, 4'd4, 4'd7, KEY_STAR: key_col = COL0;
      4'd2, 4'd5, 4'd8, 4'd0:     key_col = COL1;
      4'd3, 4'd6, 4'd9, KEY_HASH: key_col = COL2;
      default:                    key_col = 3'b000;
    endcase
  endfunction

  // Row line a key pulls; 0 for illegal codes.
  function automatic logic [3:0] key_row(input logic [3:0] code);
    case (code)
      4'd1, 4'd2, 4'd3:           key_row = 4'b1000;
      4'd4, 4'd5, 4'd6:           key_row = 4'b0100;
      4'd7, 4'd8, 4'd9:           key_row = 4'b0010;
      4'd0, KEY_STAR, KEY_HASH:   key_row = 4'b0001;
      default:                    key_row = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/scan_round_detect.sv
// Flags the first cycle of each scan round: column 0 selected after
// any other column value.
module scan_round_detect
  import keypad_pkg::*;
(
  input  logic       fin,
  input  logic       rst,
  input  logic [2:0] scan_key,
  output logic       scan_start
);

  logic [2:0] prev_scan;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge fin or posedge rst) begin
    if (rst) prev_scan <= '0;
    else     prev_scan <= scan_key;
  end

  assign scan_start = (scan_key == COL0) && (prev_scan != COL0);

endmodule

// File: rtl/keypad_emulator.sv
// Keypad-side responder: accepts key requests and presses the key on the
// row lines for HOLD_SCANS whole scan rounds, then releases for GAP_SCANS.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS = 4,
  parameter int GAP_SCANS  = 2
) (
  input  logic       fin,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  output logic       req_err,
  input  logic [2:0] scan_key,
  output logic [3:0] touch_key,
  output logic       busy
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_SCANS - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_SCANS - 1);

  kp_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_q;
  logic       scan_start;
  logic       accept;
  logic       legal;

  scan_round_detect u_round (
    .fin        (fin),
    .rst        (rst),
    .scan_key   (scan_key),
    .scan_start (scan_start)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;
  assign legal     = (req_key <= KEY_HASH);

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept && legal) state_d = ARM;
      ARM: begin
        if (scan_start) begin
          state_d = PRESS;
          cnt_d   = '0;
        end
      end
      PRESS: begin
        if (scan_start) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (scan_start) begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row drive uses the current state, so it trails scan_key by one cycle.
  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      req_err   <= 1'b0;
      touch_key <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && legal) key_q <= req_key;
      req_err <= accept && !legal;
      if (state_q == PRESS && scan_key == key_col(key_q)) touch_key <= key_row(key_q);
      else                                                touch_key <= '0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: a round-counting reference model
// is compared on every cycle, plus literal checks on directed scenarios.
module tb_keypad_emulator;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       fin = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;
  logic       req_err;
  logic [2:0] scan_key;
  logic [3:0] touch_key;
  logic       busy;

  keypad_emulator #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP)) dut (
    .fin       (fin),
    .rst       (rst),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_ready (req_ready),
    .req_err   (req_err),
    .scan_key  (scan_key),
    .touch_key (touch_key),
    .busy      (busy)
  );

  always #5 fin = ~fin;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keypad geometry from the key layout, independent of the RTL tables.
  function automatic logic [2:0] m_col(input int k);
    int c;
    if (k == 0)       c = 1;
    else if (k == 10) c = 0;
    else if (k == 11) c = 2;
    else              c = (k - 1) % 3;
    return 3'b100 >> c;
  endfunction

  function automatic logic [3:0] m_row(input int k);
    int r;
    if (k >= 1 && k <= 9) r = (k - 1) / 3;
    else                  r = 3;
    return 4'b1000 >> r;
  endfunction

  // Model: after acceptance, count round starts. Starts 1..HOLD are pressed,
  // HOLD+1..HOLD+GAP released, start HOLD+GAP+1 returns to idle.
  bit         m_active;
  int         m_starts;
  int         m_key;
  logic [2:0] m_prev;
  logic [3:0] m_touch;
  logic       m_err;

  initial begin
    bit pressing;
    bit ss;
    forever begin
      @(posedge fin or posedge rst);
      if (rst) begin
        m_active = 0; m_starts = 0; m_key = 0;
        m_prev = '0; m_touch = '0; m_err = 1'b0;
      end else begin
        pressing = m_active && m_starts >= 1 && m_starts <= HOLD;
        m_touch  = (pressing && scan_key == m_col(m_key)) ? m_row(m_key) : 4'b0;
        ss       = (scan_key == 3'b100) && (m_prev != 3'b100);
        m_err    = 1'b0;
        if (!m_active) begin
          if (req_valid) begin
            if (req_key <= 4'd11) begin
              m_active = 1; m_key = int'(req_key); m_starts = 0;
            end else begin
              m_err = 1'b1;
            end
          end
        end else if (ss) begin
          m_starts++;
          if (m_starts == HOLD + GAP + 1) m_active = 0;
        end
        m_prev = scan_key;
      end
    end
  end

  // Every-cycle comparison plus activity counters for directed checks.
  int         touch_cnt = 0;
  int         rdy_cnt   = 0;
  logic [3:0] last_touch = '0;

  initial begin
    forever begin
      @(negedge fin);
      check("touch_key", 32'(touch_key), 32'(m_touch));
      check("req_err",   32'(req_err),   32'(m_err));
      check("req_ready", 32'(req_ready), 32'(!m_active));
      check("busy",      32'(busy),      32'(m_active));
      if (touch_key != 4'b0) begin
        touch_cnt++;
        last_touch = touch_key;
      end
      if (req_ready && req_valid) rdy_cnt++;
    end
  end

  // Scanner: rotates columns; in random mode uses short dwells and glitches.
  bit scan_on   = 0;
  bit scan_rand = 0;

  initial begin
    int dwell_left;
    int col_idx;
    dwell_left = 0;
    col_idx    = 0;
    scan_key   = 3'b000;
    forever begin
      @(posedge fin);
      #2;
      if (scan_on) begin
        if (dwell_left == 0) begin
          if (scan_rand && $urandom_range(0, 7) == 0) begin
            scan_key   = 3'($urandom_range(0, 7));
            dwell_left = $urandom_range(1, 4);
          end else begin
            scan_key   = 3'b100 >> col_idx;
            col_idx    = (col_idx + 1) % 3;
            dwell_left = scan_rand ? $urandom_range(1, 10) : 16;
          end
        end
        dwell_left--;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge fin);
      #2;
    end
  endtask

  task automatic send(input logic [3:0] k);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'b1;
      req_key   = k;
      if (req_ready) begin
        step(1);
        ok = 1;
        break;
      end
      step(1);
    end
    req_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic press_and_measure(input logic [3:0] k, input logic [3:0] row, input string name);
    int base;
    base = touch_cnt;
    send(k);
    wait_idle(2000);
    check({name, "_cycles"}, 32'(touch_cnt - base), 32'd64);
    check({name, "_row"}, 32'(last_touch), 32'(row));
    check({name, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int  base;
    bit  seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_key   = '0;
    step(3);
    check("rst_touch", 32'(touch_key), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_err",   32'(req_err),   32'd0);
    rst = 1'b0;
    step(2);

    // Idle scanning: no row activity.
    scan_on = 1;
    base    = touch_cnt;
    step(100);
    check("idle_touch_cnt", 32'(touch_cnt - base), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_busy",  32'(busy),      32'd0);

    // Each press is 4 rounds of 16 cycles on the key's column.
    press_and_measure(4'd5,  4'b0100, "key5");
    press_and_measure(4'd11, 4'b0001, "key_hash");
    press_and_measure(4'd10, 4'b0001, "key_star");

    // Illegal code rejected, next request accepted immediately after.
    req_valid = 1'b1;
    req_key   = 4'd13;
    step(1);
    check("err_pulse", 32'(req_err),   32'd1);
    check("err_ready", 32'(req_ready), 32'd1);
    req_key = 4'd0;
    step(1);
    req_valid = 1'b0;
    check("err_clear",   32'(req_err), 32'd0);
    check("key0_accept", 32'(busy),    32'd1);
    wait_idle(2000);

    // Asynchronous reset in the middle of a press.
    send(4'd1);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (touch_key != 4'b0) begin
        seen = 1;
        break;
      end
    end
    check("key1_pressed", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_touch", 32'(touch_key), 32'd0);
    check("async_ready", 32'(req_ready), 32'd1);
    step(2);
    rst  = 1'b0;
    base = touch_cnt;
    step(200);
    check("post_rst_touch", 32'(touch_cnt - base), 32'd0);
    check("post_rst_ready", 32'(req_ready),        32'd1);

    // Held request waits out the busy period, accepted on first idle cycle.
    send(4'd1);
    req_valid = 1'b1;
    req_key   = 4'd2;
    base      = rdy_cnt;
    wait_idle(2000);
    step(1);
    req_valid = 1'b0;
    check("held_accept", 32'(busy),              32'd1);
    check("held_ready",  32'(rdy_cnt - base),    32'd1);
    wait_idle(2000);

    // Random requests, noise on req_valid, scan glitches and stray resets.
    scan_rand = 1;
    for (int it = 0; it < 40; it++) begin
      step($urandom_range(0, 20));
      if ($urandom_range(0, 14) == 0) begin
        #1 rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      send(4'($urandom_range(0, 15)));
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) begin
        req_valid = 1'($urandom_range(0, 1));
        req_key   = 4'($urandom_range(0, 15));
        step(1);
      end
      req_valid = 1'b0;
      wait_idle(4000);
    end
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
